// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the two-master data-RAM arbiter.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_M0   = 2'd1,
    ARB_M1   = 2'd2
  } arb_state_e;

  localparam logic ARB_MID_M0 = 1'b0;
  localparam logic ARB_MID_M1 = 1'b1;

endpackage

// File: rtl/dram_arb_perf.sv
// Per-master wait-cycle counters (requesting but not granted); wrap at 2^32.
module dram_arb_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  gnt,
  output logic [31:0] perf_m0_wait,
  output logic [31:0] perf_m1_wait
);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_m0_wait <= '0;
      perf_m1_wait <= '0;
    end else begin
      if (req[0] && !gnt[0]) perf_m0_wait <= perf_m0_wait + 32'd1;
      if (req[1] && !gnt[1]) perf_m1_wait <= perf_m1_wait + 32'd1;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the single-port data RAM between
// the CPU (M0) and a loader/DMA engine (M1). Optional perf counters: DRAM_ARB_PERF_EN.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
`ifdef DRAM_ARB_PERF_EN
  ,
  output logic [31:0] perf_m0_wait,
  output logic [31:0] perf_m1_wait
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic            last;
  logic            gnt0_c;
  logic            gnt1_c;

  // Grant decision; depends only on requests, rst and arbiter state.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    unique case (state)
      ARB_M0: begin
        if (m0_req && ((cnt < CNT_MAX) || !m1_req)) gnt0_c = 1'b1;
        else if (m1_req)                            gnt1_c = 1'b1;
      end
      ARB_M1: begin
        if (m1_req && ((cnt < CNT_MAX) || !m0_req)) gnt1_c = 1'b1;
        else if (m0_req)                            gnt0_c = 1'b1;
      end
      default: begin
        if (m0_req && m1_req) begin
          if (last == ARB_MID_M1) gnt0_c = 1'b1;
          else                    gnt1_c = 1'b1;
        end else begin
          gnt0_c = m0_req;
          gnt1_c = m1_req;
        end
      end
    endcase
    if (rst) begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
    end
  end

  // Datapath mux: the granted master drives the RAM, otherwise all zero.
  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    if (gnt0_c) begin
      mem_we         = m0_we;
      mem_addr       = m0_addr;
      mem_write_data = m0_wdata;
    end else if (gnt1_c) begin
      mem_we         = m1_we;
      mem_addr       = m1_addr;
      mem_write_data = m1_wdata;
    end
  end

  assign m0_gnt   = gnt0_c;
  assign m1_gnt   = gnt1_c;
  assign m0_rdata = mem_read_data;
  assign m1_rdata = mem_read_data;

  // Owner / burst-length / last-granted tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      cnt   <= '0;
      last  <= ARB_MID_M1;
    end else if (gnt0_c) begin
      if (state == ARB_M0) begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
      end else begin
        state <= ARB_M0;
        cnt   <= CNT_ONE;
        last  <= ARB_MID_M0;
      end
    end else if (gnt1_c) begin
      if (state == ARB_M1) begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
      end else begin
        state <= ARB_M1;
        cnt   <= CNT_ONE;
        last  <= ARB_MID_M1;
      end
    end else begin
      state <= ARB_IDLE;
      cnt   <= '0;
    end
  end

`ifdef DRAM_ARB_PERF_EN
  dram_arb_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .req          ({m1_req, m0_req}),
    .gnt          ({gnt1_c, gnt0_c}),
    .perf_m0_wait (perf_m0_wait),
    .perf_m1_wait (perf_m1_wait)
  );
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// Randomized + directed bench for dram_arbiter against a behavioural grant/RAM model.
module tb_dram_arbiter;
  import dram_arb_pkg::*;

  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_write_data, mem_read_data;
`ifdef DRAM_ARB_PERF_EN
  logic [31:0] perf_m0_wait, perf_m1_wait;
`endif

  always #5 clk = ~clk;

  dram_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
`ifdef DRAM_ARB_PERF_EN
    , .perf_m0_wait(perf_m0_wait), .perf_m1_wait(perf_m1_wait)
`endif
  );

  // The RAM itself: combinational read, write at the clock edge.
  logic [31:0] mem [256];
  logic        mem_clr;
  assign mem_read_data = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_write_data;
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [256];
  int m_owner, m_beats, m_last, m_p0, m_p1;
  int n_checks, n_errors;

  logic        obs_g0, obs_g1, obs_we;
  logic [31:0] obs_addr, obs_rd0;
  int          obs_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Which master the rules say gets the RAM this cycle (-1: none).
  function automatic int exp_grant();
    int o;
    bit ro, rx;
    if (rst) return -1;
    if (m_owner < 0) begin
      if (m0_req && m1_req) return (m_last == 0) ? 1 : 0;
      if (m0_req) return 0;
      if (m1_req) return 1;
      return -1;
    end
    o  = m_owner;
    ro = (o == 0) ? m0_req : m1_req;
    rx = (o == 0) ? m1_req : m0_req;
    if (ro && (m_beats < MB || !rx)) return o;
    if (rx) return 1 - o;
    return -1;
  endfunction

  task automatic cycle();
    int g;
    logic        e_we;
    logic [31:0] e_addr, e_wd;
    @(negedge clk);
    g      = exp_grant();
    e_we   = (g == 0) ? m0_we    : (g == 1) ? m1_we    : 1'b0;
    e_addr = (g == 0) ? m0_addr  : (g == 1) ? m1_addr  : 32'd0;
    e_wd   = (g == 0) ? m0_wdata : (g == 1) ? m1_wdata : 32'd0;
    check("m0_gnt", 32'(m0_gnt), 32'(g == 0));
    check("m1_gnt", 32'(m1_gnt), 32'(g == 1));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_write_data, e_wd);
    if (g == 0 && !e_we) check("m0_rdata", m0_rdata, ref_mem[e_addr[9:2]]);
    if (g == 1 && !e_we) check("m1_rdata", m1_rdata, ref_mem[e_addr[9:2]]);
    check("cnt", 32'(dut.cnt), 32'((m_beats < MB) ? m_beats : MB));
`ifdef DRAM_ARB_PERF_EN
    check("perf0", perf_m0_wait, 32'(m_p0));
    check("perf1", perf_m1_wait, 32'(m_p1));
`endif
    obs_g0   = m0_gnt;
    obs_g1   = m1_gnt;
    obs_we   = mem_we;
    obs_addr = mem_addr;
    obs_rd0  = m0_rdata;
    obs_cnt  = int'(dut.cnt);
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_beats = 0; m_last = 1; m_p0 = 0; m_p1 = 0;
    end else begin
      if (m0_req && g != 0) m_p0++;
      if (m1_req && g != 1) m_p1++;
      if (g < 0) begin
        m_owner = -1; m_beats = 0;
      end else if (g == m_owner) begin
        m_beats++;
      end else begin
        m_owner = g; m_beats = 1; m_last = g;
      end
      if (g >= 0 && e_we) ref_mem[e_addr[9:2]] = e_wd;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    m_owner = -1; m_beats = 0; m_last = 1; m_p0 = 0; m_p1 = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    {m0_req, m0_we, m1_req, m1_we} = '0;
    m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
    rst = 1'b1;
    mem_clr = 1'b1;
    @(posedge clk); #1;
    mem_clr = 1'b0;
    do_reset();
    check("rst_state_idle", 32'(dut.state == ARB_IDLE), 32'd1);

    // Uncontended write then read by M0.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h100; m0_wdata = 32'hDEADBEEF;
    cycle();
    check("unc_wr_gnt", {30'd0, obs_g1, obs_g0}, 32'd1);
    check("unc_wr_we", 32'(obs_we), 32'd1);
    m0_we = 1'b0;
    cycle();
    check("unc_rd_gnt", {30'd0, obs_g1, obs_g0}, 32'd1);
    check("unc_rd_we", 32'(obs_we), 32'd0);
    check("unc_rd_data", obs_rd0, 32'hDEADBEEF);
    m0_req = 1'b0;

    // First tie after reset: M0 x4, M1 x4, ...
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b1;
    m1_addr = 32'h40; m1_wdata = 32'h1234_5678;
    for (int i = 0; i < 16; i++) begin
      cycle();
      check("tie_seq", {30'd0, obs_g1, obs_g0}, ((i / MB) % 2 == 0) ? 32'd1 : 32'd2);
    end
`ifdef DRAM_ARB_PERF_EN
    check("tie_perf0", perf_m0_wait, 32'd8);
    check("tie_perf1", perf_m1_wait, 32'd8);
`endif
    m0_req = 1'b0; m1_req = 1'b0;
    cycle();

    // Sole requester is never throttled.
    m1_req = 1'b1; m1_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("sole_m1_gnt", 32'(obs_g1), 32'd1);
    end
    check("sole_cnt_sat", 32'(obs_cnt), 32'(MB));

    // Mid-burst contention: M0 gets in at once, then M1 restarts its burst.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    cycle();
    check("mid_m0_gnt", 32'(obs_g0), 32'd1);
    m0_req = 1'b0;
    cycle();
    check("mid_m1_resume", 32'(obs_g1), 32'd1);
    cycle();
    check("mid_cnt_one", 32'(obs_cnt), 32'd1);
    m1_req = 1'b0;
    cycle();

    // Reset during an M1 burst.
    m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b1; m1_we = 1'b1;
    m0_wdata = 32'hAAAA_0000; m1_wdata = 32'h5555_0000;
    for (int i = 0; i < 20 && !(m_owner == 1 && m_beats >= 2); i++) cycle();
    check("rst_mid_m1_burst", 32'(obs_g1), 32'd1);
    rst = 1'b1;
    cycle();
    check("rst_gnt", {30'd0, obs_g1, obs_g0}, 32'd0);
    check("rst_we", 32'(obs_we), 32'd0);
    rst = 1'b0;
    cycle();
    check("rst_after_m0", {30'd0, obs_g1, obs_g0}, 32'd1);
    m0_req = 1'b0; m1_req = 1'b0;

    // Idle.
    for (int i = 0; i < 5; i++) begin
      m0_addr = $urandom; m1_addr = $urandom; m0_we = 1'b1; m1_we = 1'b1;
      cycle();
      check("idle_we", 32'(obs_we), 32'd0);
      check("idle_addr", obs_addr, 32'd0);
    end
    check("idle_state", 32'(dut.state == ARB_IDLE), 32'd1);

    // Randomized traffic; a waiting master keeps its request up.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (!(m0_req && !obs_g0)) m0_req = ($urandom_range(0, 2) != 0);
      if (!(m1_req && !obs_g1)) m1_req = ($urandom_range(0, 2) != 0);
      m0_we = $urandom_range(0, 1) == 1;
      m1_we = $urandom_range(0, 1) == 1;
      m0_addr = {22'd0, 8'($urandom), 2'b00};
      m1_addr = {22'd0, 8'($urandom), 2'b00};
      m0_wdata = $urandom;
      m1_wdata = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

- Shares the single-port data RAM (`MEM`, combinational read, write on clock edge) between two requesters: master 0 (the CPU data port) and master 1 (a loader/DMA engine).
- Sits between those masters and `MEM`, and drives the RAM address, write-enable and write-data.
- Arbitration is round-robin with a bounded burst. A master losing arbitration sees its grant low and must hold its request; the CPU uses `m0_req && !m0_gnt` as its stall condition.

## Interface
- `MAX_BURST`, default 4: maximum consecutive granted beats for one master while the other master is requesting. Legal range is 1..255.
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: one clock; reset is synchronous and active-high.
- `m0_req` / `m1_req`  in  1: access request. Level-sensitive; held until a cycle in which the matching grant is high.
- `m0_we` / `m1_we`  in  1: write request (1) or read request (0).
- `m0_addr` / `m1_addr`  in  32: byte address.
- `m0_wdata` / `m1_wdata`  in  32: write data.
- `m0_gnt` / `m1_gnt`  out  1: access performed this cycle.
- `m0_rdata` / `m1_rdata`  out  32: read data. Equals `mem_read_data`; valid only in a cycle where the matching grant is high.
- `mem_we`  out  1: RAM write enable.
- `mem_addr`  out  32: RAM address.
- `mem_write_data`  out  32: RAM write data.
- `mem_read_data`  in  32: RAM combinational read data.
- `perf_m0_wait` / `perf_m1_wait`  out  32: wait-cycle counters. Present only with `DRAM_ARB_PERF_EN`.

## Operation
- **Registers:**
  - `state`: ARB_IDLE, ARB_M0 or ARB_M1, the owner in the previous cycle.
  - `cnt`: consecutive beats of the current owner, width `$clog2(MAX_BURST+1)`, saturating at `MAX_BURST`.
  - `last`: the master granted most recently.
- **Grant decision (combinational, every cycle).** Here O is the owner given by `state` and X is the other master.
  - In ARB_IDLE:
    - one requester: grant it;
    - both requesting: grant the master that is not `last`.
  - In ARB_M0 or ARB_M1:
    - grant O if O requests and (`cnt < MAX_BURST` or X is not requesting);
    - otherwise grant X if X requests;
    - otherwise grant nobody.
  - At most one grant is high in any cycle.
- **Datapath mux.**
  - The granted master's `we`, `addr` and `wdata` drive `mem_we`, `mem_addr` and `mem_write_data`.
  - With no grant: `mem_we=0`, `mem_addr=0`, `mem_write_data=0`.
- **Next-state rules:**
  - Granted master G equals O: `state` stays, `cnt=min(cnt+1,MAX_BURST)`.
  - G differs from O, or state was ARB_IDLE: `state` becomes G, `cnt=1`, `last=G`.
  - No grant: `state=ARB_IDLE`, `cnt=0`, `last` unchanged.
- **Reset.** While `rst` is high:
  - both grants and `mem_we` are forced to 0 combinationally;
  - on the edge: `state=ARB_IDLE`, `cnt=0`, `last=M1` (M0 wins the first tie), perf counters 0.
- **Reset mid-burst.** An access that coincides with `rst` high is not performed. The master keeps requesting and is re-arbitrated after reset.
- **Boundary cases:**
  - `MAX_BURST=1` gives strict alternation under contention.
  - A sole requester is never starved or throttled: `cnt` saturates and the grant continues.
  - Request/we/addr changes while not granted have no effect on the RAM.

## Timing
- Grant latency:
  - 0 cycles when uncontended: the grant rises in the same cycle as the request.
  - Worst case under contention: `MAX_BURST` cycles.
- Reads complete in the granted cycle; `rdata` is combinational through `MEM`.
- Writes commit at the rising edge that ends the granted cycle.
- No combinational path from `mem_read_data` to any grant.
- Outputs with no registered stage: grant, mem_* and rdata are all combinational from the inputs plus `state`/`cnt`/`last`.

## Configuration
- `DRAM_ARB_PERF_EN`:
  - **Defined:** `perf_m0_wait`/`perf_m1_wait` exist. Each increments by 1 every cycle in which that master requests and is not granted, wraps at 2^32, and is cleared by `rst`.
  - **Undefined:** the ports and counters are absent; arbitration behaviour is identical.

## Structure
- Shared package `dram_arb_pkg`:
  - state enum `arb_state_e` (ARB_IDLE, ARB_M0, ARB_M1);
  - master-id constants `ARB_MID_M0=0`, `ARB_MID_M1=1`.
- One sub-module `dram_arb_perf`, instantiated only under `DRAM_ARB_PERF_EN`:
  - inputs: `clk`, `rst`, `req[1:0]`, `gnt[1:0]`;
  - outputs: the two 32-bit wait counters.
- Grant logic, FSM and datapath mux stay in `dram_arbiter`.

## Test plan
- **Uncontended traffic.** M0 writes 0xDEADBEEF to 0x100, then reads 0x100.
  - `m0_gnt=1` in both cycles; `mem_we=1` only in the first; `m0_rdata=0xDEADBEEF` in the second.
  - `m1_gnt=0` throughout.
- **First tie after reset.** Both masters request continuously from the first cycle after reset, `MAX_BURST=4`.
  - Grant sequence: M0×4, M1×4, M0×4, ...
  - With `DRAM_ARB_PERF_EN`: after 16 cycles, `perf_m0_wait=8` and `perf_m1_wait=8`.
- **Sole requester not throttled.** M1 requests for 10 cycles, M0 idle: `m1_gnt=1` for all 10 cycles and `cnt` holds at 4.
- **Mid-burst contention.** M1 is at beat 4 when M0 raises its request.
  - M0 is granted on the very next cycle.
  - With M0 requesting a single beat, M1 resumes with `cnt=1` in the following cycle.
- **Reset during contention.** Both masters request; `rst` is asserted for 1 cycle in the middle of an M1 burst.
  - Both grants are 0 and `mem_we=0` in that cycle.
  - In the next cycle M0 is granted (`last=M1` tie-break).
- **Idle behaviour.** No requests for 5 cycles: `mem_we=0` and `mem_addr=0`, and the FSM stays in ARB_IDLE.
